vga_scan_ctrl: RTL and testbench
================================

Name: vga_scan_ctrl

Overview:
- Generates 640x480@60 VGA timing from the system clock and scans the tile map in raster order.
- For every pixel it delivers the game-object category, the 10-bit sprite ROM address, the tank direction and the player flag, all aligned with pixel_x/pixel_y and sync.
- It feeds the renderer that turns category/sprite data into RGB. It is the request/drive end of that pixel interface.
- Screen is 20x15 tiles of 32x32 pixels, with the map held in an external synchronous RAM.

Parameters:
CLK_DIV, 4, system clocks per pixel; legal values >= 3.
H_ACTIVE, 640, visible pixels per line.
H_FP, 16, horizontal front porch in pixels.
H_SYNC, 96, hsync pulse width in pixels.
H_BP, 48, horizontal back porch in pixels.
V_ACTIVE, 480, visible lines.
V_FP, 10, vertical front porch in lines.
V_SYNC, 2, vsync pulse width in lines.
V_BP, 33, vertical back porch in lines.
MAP_COLS, 20, tiles per map row.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
map_addr  out  9  tile-map RAM read address, row*MAP_COLS+col
map_data  in  8  RAM read data, 1-clk latency; [7:4] category, [3:1] direction, [0] player flag
pixel_x  out  10  column of the current output pixel
pixel_y  out  10  row of the current output pixel
category  out  4  0 NONE, 1 WALL, 2 TANK, 3 BULLET
addr  out  10  sprite pixel address, (y mod 32)*32 + (x mod 32)
tank_direct  out  3  direction code from the map entry
player_tank  out  1  player flag from the map entry
video_on  out  1  high while the output pixel is inside the active area
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
frame_start  out  1  one-clk pulse when the output pixel becomes (0,0)

Behaviour:
- Clock divider: a 0..CLK_DIV-1 counter produces pix_tick, one clk wide, every CLK_DIV clks. The first tick occurs CLK_DIV clks after reset release.
- Counters: h_cnt counts 0..H_TOTAL-1, with H_TOTAL = 800. v_cnt counts 0..V_TOTAL-1, with V_TOTAL = 525.
  - Both counters advance only on pix_tick.
  - h_cnt wraps to 0 and v_cnt increments in the same tick.
  - When v_cnt is V_TOTAL-1 at that wrap, v_cnt wraps to 0.
- Address generation:
  - map_addr = (v_cnt>>5)*MAP_COLS + (h_cnt>>5), computed from the registered counters.
  - map_addr is forced to 0 outside the active area, so its range is 0..299.
  - Multiply by constant 20 as (r<<4)+(r<<2), using 9-bit arithmetic.
- Pipeline (tick in clk T):
  - T+1: the counters hold the new value and map_addr is stable.
  - T+2: map_data is valid.
  - At the end of T+2, all outputs are registered together from delayed copies of the counters plus map_data.
  - All outputs therefore change exactly 2 clks after pix_tick and hold for CLK_DIV clks.
- Syncs and video_on at the output register:
  - hsync = 0 iff h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656,751].
  - vsync = 0 iff v in [490,491].
  - video_on = (h < 640) && (v < 480).
- Category and sprite outputs:
  - When video_on is 0: category = 0 and addr = 0; tank_direct and player_tank hold their last values.
  - When video_on is 1: addr = {y[4:0], x[4:0]}, tank_direct = map_data[3:1], player_tank = map_data[0].
- Category mapping when video_on is 1:
  - Map category 1 or 2 passes through unchanged.
  - Map category 3 (BULLET) is output as 3 only when x mod 32 and y mod 32 are both in [12,19]; otherwise it is output as 0.
  - Map category 0 or >= 4 is output as 0.
- pixel_x/pixel_y: equal to the delayed h_cnt/v_cnt, including blanking values, so pixel_x reaches up to 799.
- frame_start: one clk pulse in the same clk the outputs change to h=0, v=0.
- Reset values (async assert; all state clears immediately):
  - Counters = 0 and divider = 0.
  - hsync = 1, vsync = 1.
  - video_on = 0, frame_start = 0, category = 0, addr = 0, tank_direct = 0, player_tank = 0.
  - pixel_x = 0, pixel_y = 0, map_addr = 0.
- Reset mid-frame: outputs return to the reset values within the same clk. After release the scan restarts at (0,0), with no partial-line output. The first frame_start occurs at the first output update.
- Deassertion is synchronised inside the block with a 2-flop release. The first pix_tick is counted from the synchronised release.

Test Plan:
- Reset check: hold rst_n=0, then release -> all outputs at reset values. After CLK_DIV+2 clks pixel_x=1; frame_start pulses at the first update to (0,0).
- Line timing: run one line -> hsync low for exactly 96 pixel periods starting at pixel_x=656. The line is 800*4=3200 clks; video_on is high for pixel_x 0..639.
- Frame timing: run one frame -> vsync low on lines 490-491 only. frame_start recurs every 525*3200=1,680,000 clks.
- Map lookup: RAM model has entry 41 = 8'h23 (TANK, dir 1, player 1). Pixel (37,70) -> map_addr=41 one clk after its tick. Outputs category=2, addr=197, tank_direct=1, player_tank=1, aligned with pixel_x=37, pixel_y=70.
- Bullet shaping: entry 0 = 8'h30. Pixel (12,12) -> category 3; pixel (11,12) -> category 0; pixel (19,19) -> category 3; pixel (20,19) -> category 0.
- Blanking and mid-frame reset: pixel (700,100) -> category=0, addr=0, video_on=0. Assert rst_n at pixel (300,200) -> outputs reset immediately, and the scan resumes from (0,0) after release.

Source files
------------

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: 640x480@60 VGA raster scan with tile-map lookup.
// Drives per-pixel category/sprite data aligned with pixel_x/pixel_y/sync.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   map_addr  [8:0]     tile-map RAM address, row*MAP_COLS+col
//   map_data  [7:0]     RAM data, 1-clk latency: cat/dir/player
//   pixel_x/y [9:0]     position of the current output pixel
//   category  [3:0]     0 none, 1 wall, 2 tank, 3 bullet
//   addr      [9:0]     sprite pixel address {y[4:0],x[4:0]}
//   tank_direct [2:0]   direction code from the map entry
//   player_tank         player flag from the map entry
//   video_on            output pixel inside the active area
//   hsync, vsync        active-low syncs
//   frame_start         one-clk pulse when output becomes (0,0)

module vga_scan_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int MAP_COLS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [8:0] map_addr,
  input  logic [7:0] map_data,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic [3:0] category,
  output logic [9:0] addr,
  output logic [2:0] tank_direct,
  output logic       player_tank,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [1:0]    rst_sync;
  logic          run;
  logic [DW-1:0] div;
  logic          primed;
  logic          pix_tick;
  logic          prime;
  logic          adv;
  logic          adv_d;
  logic          load;
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic [9:0]    h_d;
  logic [9:0]    v_d;
  logic          act;
  logic [8:0]    row9;
  logic [8:0]    col9;
  logic [8:0]    row_x;
  logic          von_nxt;
  logic          in_dot;
  logic [3:0]    cat_nxt;

  // 2-flop release; assertion still clears everything at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run = rst_sync[1];

  // The first run cycle is a priming slot: it pushes the reset
  // position (0,0) through the pipeline without moving the counters,
  // so the scan visibly starts at (0,0) with a frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      primed <= 1'b0;
    end else if (run) begin
      div <= (div == DIV_LAST) ? '0 : div + DW'(1);
      if (div == '0) primed <= 1'b1;
    end
  end

  assign pix_tick = run && primed && (div == '0);
  assign prime    = run && !primed;
  assign adv      = pix_tick | prime;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign act  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign row9 = 9'(v_cnt[9:5]);
  assign col9 = 9'(h_cnt[9:5]);

  generate
    if (MAP_COLS == 20) begin : g_x20
      assign row_x = (row9 << 4) + (row9 << 2);
    end else begin : g_xn
      assign row_x = row9 * 9'(MAP_COLS);
    end
  endgenerate

  assign map_addr = act ? row_x + col9 : '0;

  // Counters are stable for CLK_DIV>=3 clks, so a plain one-clk
  // delay lines them up with map_data when the output loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adv_d <= 1'b0;
      load  <= 1'b0;
      h_d   <= '0;
      v_d   <= '0;
    end else begin
      adv_d <= adv;
      load  <= adv_d;
      h_d   <= h_cnt;
      v_d   <= v_cnt;
    end
  end

  assign von_nxt = (h_d < H_ACT) && (v_d < V_ACT);
  assign in_dot  = (h_d[4:0] >= 5'd12) && (h_d[4:0] <= 5'd19) &&
                   (v_d[4:0] >= 5'd12) && (v_d[4:0] <= 5'd19);

  always_comb begin
    cat_nxt = 4'd0;
    unique case (1'b1)
      (map_data[7:4] == 4'd1),
      (map_data[7:4] == 4'd2): cat_nxt = map_data[7:4];
      (map_data[7:4] == 4'd3): cat_nxt = in_dot ? 4'd3 : 4'd0;
      default:                 cat_nxt = 4'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      category    <= '0;
      addr        <= '0;
      tank_direct <= '0;
      player_tank <= 1'b0;
      video_on    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (load) begin
        pixel_x     <= h_d;
        pixel_y     <= v_d;
        video_on    <= von_nxt;
        hsync       <= !((h_d >= H_SS) && (h_d <= H_SE));
        vsync       <= !((v_d >= V_SS) && (v_d <= V_SE));
        frame_start <= (h_d == '0) && (v_d == '0);
        if (von_nxt) begin
          category    <= cat_nxt;
          addr        <= {v_d[4:0], h_d[4:0]};
          tank_direct <= map_data[3:1];
          player_tank <= map_data[0];
        end else begin
          category <= '0;
          addr     <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: directed bench for vga_scan_ctrl.
// Uses shrunk timing so whole frames fit in a short run.

module tb_vga_scan_ctrl;

  localparam int CD  = 3;
  localparam int HA  = 64;
  localparam int HF  = 8;
  localparam int HS  = 16;
  localparam int HB  = 8;
  localparam int VA  = 96;
  localparam int VF  = 4;
  localparam int VS  = 2;
  localparam int VB  = 4;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VT  = VA + VF + VS + VB;
  localparam int LINE_CLKS  = HT * CD;
  localparam int FRAME_CLKS = HT * VT * CD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] map_addr;
  logic [7:0] map_data;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic [3:0] category;
  logic [9:0] addr;
  logic [2:0] tank_direct;
  logic       player_tank;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       frame_start;

  logic [7:0] mem [0:511];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  vga_scan_ctrl #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .MAP_COLS(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .map_addr(map_addr),
    .map_data(map_data), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .category(category), .addr(addr), .tank_direct(tank_direct),
    .player_tank(player_tank), .video_on(video_on), .hsync(hsync),
    .vsync(vsync), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    map_data <= mem[map_addr];
    cyc <= cyc + 1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_pix(input int x, input int y);
    int n;
    n = 0;
    while (!(pixel_x == 10'(x) && pixel_y == 10'(y)) &&
           n < FRAME_CLKS + 100) begin
      step();
      n++;
    end
    chk($sformatf("reach_%0d_%0d", x, y),
        int'(pixel_x == 10'(x) && pixel_y == 10'(y)), 1);
  endtask

  initial begin
    int n;
    int hl;
    int vo;
    int fx;
    int vl;
    int fy;
    int t0;
    int t1;

    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[0]  = 8'h30;
    mem[1]  = 8'h1A;
    mem[20] = 8'h4F;
    mem[21] = 8'h3E;
    mem[41] = 8'h23;

    // reset state
    rst_n = 1'b0;
    repeat (4) step();
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_von", int'(video_on), 0);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_cat", int'(category), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_dir", int'(tank_direct), 0);
    chk("rst_ply", int'(player_tank), 0);
    chk("rst_px", int'(pixel_x), 0);
    chk("rst_py", int'(pixel_y), 0);
    chk("rst_maddr", int'(map_addr), 0);

    // release: scan must open with (0,0) and a frame_start
    rst_n = 1'b1;
    step();
    chk("pre_von", int'(video_on), 0);
    n = 1;
    while (!frame_start && n < CD + 8) begin
      step();
      n++;
    end
    chk("first_fs", int'(frame_start), 1);
    t0 = cyc;
    chk("fs_px", int'(pixel_x), 0);
    chk("fs_py", int'(pixel_y), 0);
    chk("fs_von", int'(video_on), 1);
    chk("fs_hs", int'(hsync), 1);
    chk("fs_vs", int'(vsync), 1);
    step();
    chk("fs_pulse", int'(frame_start), 0);
    n = 1;
    while (pixel_x == 10'd0 && n < 20) begin
      step();
      n++;
    end
    chk("pix_hold", n, CD);
    chk("px_1", int'(pixel_x), 1);

    // wall tile, entry 1
    wait_pix(40, 10);
    chk("wall_cat", int'(category), 1);
    chk("wall_dir", int'(tank_direct), 5);
    chk("wall_ply", int'(player_tank), 0);
    chk("wall_addr", int'(addr), 328);

    // bullet shaping on entry 0
    wait_pix(11, 12);
    chk("b11_cat", int'(category), 0);
    chk("b11_addr", int'(addr), 395);
    chk("b11_maddr", int'(map_addr), 0);
    wait_pix(12, 12);
    chk("b12_cat", int'(category), 3);
    chk("b12_addr", int'(addr), 396);
    wait_pix(19, 19);
    chk("b19_cat", int'(category), 3);
    chk("b19_addr", int'(addr), 627);
    wait_pix(20, 19);
    chk("b20_cat", int'(category), 0);

    // one full line
    wait_pix(0, 20);
    hl = 0;
    vo = 0;
    fx = -1;
    for (int i = 0; i < LINE_CLKS; i++) begin
      if (!hsync) hl++;
      if (video_on) vo++;
      if (!hsync && fx < 0) fx = int'(pixel_x);
      step();
    end
    chk("hs_len", hl, HS * CD);
    chk("hs_first", fx, HA + HF);
    chk("von_len", vo, HA * CD);
    chk("line_px", int'(pixel_x), 0);
    chk("line_py", int'(pixel_y), 21);

    // category >= 4 suppressed
    wait_pix(5, 40);
    chk("c4_cat", int'(category), 0);
    chk("c4_dir", int'(tank_direct), 7);
    chk("c4_ply", int'(player_tank), 1);
    chk("c4_addr", int'(addr), 261);

    // horizontal blanking: dir/player hold from (63,40)
    wait_pix(80, 40);
    chk("blk_von", int'(video_on), 0);
    chk("blk_cat", int'(category), 0);
    chk("blk_addr", int'(addr), 0);
    chk("blk_dir", int'(tank_direct), 7);
    chk("blk_ply", int'(player_tank), 0);
    chk("blk_maddr", int'(map_addr), 0);

    // bullet dot in tile 21
    wait_pix(45, 44);
    chk("b21_cat", int'(category), 3);
    chk("b21_addr", int'(addr), 397);
    chk("b21_ply", int'(player_tank), 0);

    // player tank, entry 41
    wait_pix(37, 70);
    chk("tank_maddr", int'(map_addr), 41);
    chk("tank_cat", int'(category), 2);
    chk("tank_addr", int'(addr), 197);
    chk("tank_dir", int'(tank_direct), 1);
    chk("tank_ply", int'(player_tank), 1);

    // vertical blanking, vsync, frame period
    wait_pix(0, 97);
    chk("vb_von", int'(video_on), 0);
    n = 0;
    vl = 0;
    fy = -1;
    while (!frame_start && n < 4000) begin
      if (!vsync) vl++;
      if (!vsync && fy < 0) fy = int'(pixel_y);
      step();
      n++;
    end
    t1 = cyc;
    chk("vb_clks", n, (VT - 97) * LINE_CLKS);
    chk("vs_len", vl, VS * LINE_CLKS);
    chk("vs_first", fy, VA + VF);
    chk("frame_period", t1 - t0, FRAME_CLKS);
    chk("fs2_px", int'(pixel_x), 0);
    chk("fs2_py", int'(pixel_y), 0);

    // mid-frame reset
    wait_pix(30, 80);
    chk("mid_von", int'(video_on), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_px", int'(pixel_x), 0);
    chk("mr_py", int'(pixel_y), 0);
    chk("mr_von", int'(video_on), 0);
    chk("mr_hs", int'(hsync), 1);
    chk("mr_maddr", int'(map_addr), 0);
    step();
    step();
    rst_n = 1'b1;
    n = 0;
    while (!frame_start && n < CD + 8) begin
      step();
      n++;
    end
    chk("mr_fs", int'(frame_start), 1);
    chk("mr_fs_px", int'(pixel_x), 0);
    chk("mr_fs_py", int'(pixel_y), 0);
    wait_pix(2, 0);
    chk("mr_run_addr", int'(addr), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
